// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: streams A/B operands from two 1-cycle-latency memories and
// multiply-accumulates them. Define DOT_PRODUCT_CTRL_SAT_EN for saturating accumulation.
module dot_product_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned ACC_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH:0]     length,
   output logic                    busy,
   output logic                    mem_read_en,
   output logic [ADDR_WIDTH-1:0]   mem_read_address,
   input  logic [DATA_WIDTH-1:0]   mem_a_data,
   input  logic [DATA_WIDTH-1:0]   mem_b_data,
   output logic [ACC_WIDTH-1:0]    result,
   output logic                    result_valid,
   input  logic                    result_ready
);

   localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;
   localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [ADDR_WIDTH-1:0]  addr, addr_nxt;
   logic [ADDR_WIDTH-1:0]  last_addr, last_addr_nxt;
   logic [ACC_WIDTH-1:0]   acc, acc_nxt, acc_sum;
   logic [ACC_WIDTH-1:0]   prod_acc;
   logic [PROD_WIDTH-1:0]  prod;
   logic [LEN_WIDTH-1:0]   len_clamped;
   logic                   rd_vld;

   // Product of the operand pair returned this cycle, sized to the accumulator
   always_comb begin
      prod     = PROD_WIDTH'(mem_a_data) * PROD_WIDTH'(mem_b_data);
      prod_acc = ACC_WIDTH'(prod);
   end

`ifdef DOT_PRODUCT_CTRL_SAT_EN
   localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
   logic [SUM_WIDTH-1:0] sum_wide;

   // Adding a non-negative term to max overflows again, so max sticks until cleared
   always_comb begin
      sum_wide = SUM_WIDTH'(acc) + SUM_WIDTH'(prod_acc);
      acc_sum  = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
   end
`else
   always_comb begin
      acc_sum = acc + prod_acc;
   end
`endif

   always_comb begin
      len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      addr_nxt      = addr;
      last_addr_nxt = last_addr;
      acc_nxt       = rd_vld ? acc_sum : acc;
      case (state)
         IDLE: begin
            if (start) begin
               acc_nxt  = '0;
               addr_nxt = '0;
               if (length != '0) begin
                  state_nxt     = READ;
                  last_addr_nxt = ADDR_WIDTH'(len_clamped - LEN_WIDTH'(1));
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         READ: begin
            if (addr == last_addr) begin
               state_nxt = DRAIN;
            end else begin
               addr_nxt = addr + ADDR_WIDTH'(1);
            end
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            if (result_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath and output registers; outputs follow the next state so they align with it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr         <= '0;
         last_addr    <= '0;
         acc          <= '0;
         rd_vld       <= 1'b0;
         busy         <= 1'b0;
         mem_read_en  <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
      end else begin
         addr         <= addr_nxt;
         last_addr    <= last_addr_nxt;
         acc          <= acc_nxt;
         rd_vld       <= mem_read_en;
         busy         <= (state_nxt != IDLE);
         mem_read_en  <= (state_nxt == READ);
         result_valid <= (state_nxt == DONE);
         if ((state_nxt == DONE) && (state != DONE)) begin
            result <= acc_nxt;
         end
      end
   end

   assign mem_read_address = addr;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Randomized self-checking bench for dot_product_ctrl against a cycle-offset reference model.
module tb_dot_product_ctrl;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned LW    = AW + 1;
   localparam int unsigned ACCW  = 16;
   localparam int unsigned DEPTH = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [LW-1:0]   length;
   logic            busy;
   logic            mem_read_en;
   logic [AW-1:0]   mem_read_address;
   logic [DW-1:0]   a_q, b_q;
   logic [ACCW-1:0] result;
   logic            result_valid;
   logic            result_ready;

   logic [DW-1:0]   mem_a [DEPTH];
   logic [DW-1:0]   mem_b [DEPTH];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   dot_product_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .length           (length),
      .busy             (busy),
      .mem_read_en      (mem_read_en),
      .mem_read_address (mem_read_address),
      .mem_a_data       (a_q),
      .mem_b_data       (b_q),
      .result           (result),
      .result_valid     (result_valid),
      .result_ready     (result_ready)
   );

   always #5 clk = ~clk;

   // Operand memories with one cycle of read latency
   always @(posedge clk) begin
      if (mem_read_en) begin
         a_q <= mem_a[mem_read_address];
         b_q <= mem_b[mem_read_address];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp_len(input int l);
      return (l > int'(DEPTH)) ? int'(DEPTH) : l;
   endfunction

   function automatic longint ref_dot(input int l);
      longint s = 0;
      for (int i = 0; i < l; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
`ifdef DOT_PRODUCT_CTRL_SAT_EN
      if (s > 65535) s = 65535;
`else
      s = s % 65536;
`endif
      return s;
   endfunction

   function automatic int valid_at(input int l);
      return (l == 0) ? 1 : l + 2;
   endfunction

   // Reference: offset k counts cycles since the accepting edge
   bit     m_active = 1'b0;
   int     m_k      = 0;
   int     m_len    = 0;
   longint m_sum    = 0;

   always @(posedge clk) begin
      if (rst_n !== 1'b1) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (start === 1'b1) begin
            m_len    = clamp_len(int'(length));
            m_sum    = ref_dot(m_len);
            m_k      = 1;
            m_active = 1'b1;
         end
      end else if (m_k >= valid_at(m_len) && result_ready === 1'b1) begin
         m_active = 1'b0;
      end else begin
         m_k++;
      end
   end

   always @(negedge clk) begin
      bit ev, een;
      if (chk_on) begin
         ev  = m_active && (m_k >= valid_at(m_len));
         een = m_active && (m_len > 0) && (m_k >= 1) && (m_k <= m_len);
         check("busy", 32'(busy), 32'(m_active));
         check("read_en", 32'(mem_read_en), 32'(een));
         if (een) check("read_addr", 32'(mem_read_address), 32'(m_k - 1));
         check("result_valid", 32'(result_valid), 32'(ev));
         if (ev) check("result", 32'(result), 32'(m_sum));
      end
   end

   task automatic run_txn(input int len, input int hold, output logic [ACCW-1:0] res, output int lat);
      start  = 1'b1;
      length = LW'(len);
      lat    = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat++;
      end while (result_valid !== 1'b1 && lat < 200);
      if (lat >= 200) check("valid_timeout", 32'(lat), 32'(valid_at(clamp_len(len))));
      res = result;
      for (int h = 0; h < hold; h++) begin
         result_ready = 1'b0;
         start        = 1'b1;
         length       = LW'($urandom_range(0, 20));
         @(negedge clk);
         check("held_result", 32'(result), 32'(res));
         check("held_valid", 32'(result_valid), 32'd1);
      end
      result_ready = 1'b1;
      start        = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      start        = 1'b0;
   endtask

   task automatic load_seq(input int n);
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem_a[i] = (i < n) ? DW'(i + 1) : '0;
         mem_b[i] = (i < n) ? DW'(i + 5) : '0;
      end
   endtask

   logic [ACCW-1:0] res;
   int              lat;

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      length       = '0;
      result_ready = 1'b0;
      load_seq(4);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      chk_on = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_en", 32'(mem_read_en), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_addr", 32'(mem_read_address), 32'd0);

      // A=[1,2,3,4], B=[5,6,7,8]
      run_txn(4, 0, res, lat);
      check("t1_latency", 32'(lat), 32'd6);
      check("t1_result", 32'(res), 32'd70);
      check("t1_idle", 32'(busy), 32'd0);

      run_txn(0, 0, res, lat);
      check("t2_latency", 32'(lat), 32'd1);
      check("t2_result", 32'(res), 32'd0);

      run_txn(4, 3, res, lat);
      check("t3_result", 32'(res), 32'd70);
      check("t3_idle", 32'(busy), 32'd0);

      for (int i = 0; i < int'(DEPTH); i++) begin
         mem_a[i] = 8'hFF;
         mem_b[i] = 8'hFF;
      end
      run_txn(16, 0, res, lat);
`ifdef DOT_PRODUCT_CTRL_SAT_EN
      check("t4_result", 32'(res), 32'd65535);
`else
      check("t4_result", 32'(res), 32'd57360);
`endif

      // Abort mid-read with a one-cycle reset
      load_seq(4);
      start  = 1'b1;
      length = LW'(4);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_en", 32'(mem_read_en), 32'd0);
      check("t5_valid", 32'(result_valid), 32'd0);
      check("t5_result", 32'(result), 32'd0);
      check("t5_addr", 32'(mem_read_address), 32'd0);
      load_seq(2);
      run_txn(2, 0, res, lat);
      check("t5_new_result", 32'(res), 32'd17);

      run_txn(20, 1, res, lat);
      check("t6_latency", 32'(lat), 32'd18);

      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_a[i] = DW'($urandom);
            mem_b[i] = DW'($urandom);
         end
         run_txn(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), res, lat);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
